// File: rtl/mgt_01_fsqrt_ctrl.sv
// FP32 square-root sequencer: classifies and unpacks the operand, drives a non-restoring
// sqrt core with a 2-integer-bit radicand, then rounds (RNE) and packs the result.
module mgt_01_fsqrt_ctrl #(
  parameter int unsigned DATA_WIDTH = 48,
  parameter int unsigned OUT_WIDTH  = 24,
  parameter int unsigned MAX_WAIT   = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  clk_en_i,
  input  logic                  valid_i,
  input  logic [31:0]           operand_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] core_radicand_o,
  output logic                  core_en_o,
  input  logic [OUT_WIDTH-1:0]  core_root_i,
  input  logic [OUT_WIDTH:0]    core_remainder_i,
  input  logic                  core_valid_i,
  output logic [31:0]           result_o,
  output logic                  valid_o,
  output logic                  invalid_o,
  output logic                  inexact_o,
  output logic                  core_timeout_o
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SPECIAL, S_NORM, S_ISSUE, S_WAIT, S_ROUND
  } state_t;

  state_t r_state, w_state_nx;

  logic                  w_accept, w_sign, w_is_nan, w_is_zero, w_is_special, w_is_sub;
  logic [7:0]            w_expf;
  logic [22:0]           w_frac;
  logic [31:0]           w_spec_result;
  logic                  w_spec_invalid;
  logic                  w_round_up, w_ovf;
  logic [22:0]           w_mant_rnd;
  logic [7:0]            w_er_fin;

  logic [OUT_WIDTH-1:0]  r_mant;
  logic signed [9:0]     r_exp;
  logic [7:0]            r_er;
  logic [OUT_WIDTH-1:0]  r_q;
  logic [OUT_WIDTH:0]    r_rem;
  logic [31:0]           r_spec_result;
  logic                  r_spec_invalid;
  logic [CW-1:0]         r_wait_cnt;
  logic [DATA_WIDTH-1:0] r_radicand;
  logic                  r_core_en;
  logic [31:0]           r_result;
  logic                  r_valid, r_invalid, r_inexact, r_timeout;

  assign w_sign    = operand_i[31];
  assign w_expf    = operand_i[30:23];
  assign w_frac    = operand_i[22:0];
  assign w_is_nan  = (w_expf == 8'hFF) && (w_frac != 23'd0);
  assign w_is_zero = (w_expf == 8'h00) && (w_frac == 23'd0);
  assign w_is_sub  = (w_expf == 8'h00);
  assign w_is_special = w_is_nan || w_is_zero || w_sign || (w_expf == 8'hFF);

  // Priority: NaN, then signed zero, then any negative, leaving only +inf.
  always_comb begin
    w_spec_result  = 32'h7FC0_0000;
    w_spec_invalid = 1'b1;
    if (!w_is_nan && w_is_zero) begin
      w_spec_result  = {w_sign, 31'd0};
      w_spec_invalid = 1'b0;
    end else if (!w_is_nan && !w_sign) begin
      w_spec_result  = 32'h7F80_0000;
      w_spec_invalid = 1'b0;
    end
  end

  assign ready_o  = (r_state == S_IDLE) && !r_valid;
  assign w_accept = valid_i && ready_o;

  // R > q is the exact "above half" test; a tie is impossible for a square root.
  assign w_round_up = r_rem > {1'b0, r_q};
  assign w_ovf      = w_round_up && (&r_q);
  assign w_mant_rnd = r_q[22:0] + {22'd0, w_round_up};
  assign w_er_fin   = r_er + {7'd0, w_ovf};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
    end else if (clk_en_i) begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_is_special)  w_state_nx = S_SPECIAL;
          else if (w_is_sub) w_state_nx = S_NORM;
          else               w_state_nx = S_ISSUE;
        end
      end
      S_SPECIAL: w_state_nx = S_IDLE;
      S_NORM:    if (r_mant[OUT_WIDTH-2]) w_state_nx = S_ISSUE;
      S_ISSUE:   w_state_nx = S_WAIT;
      S_WAIT:    if (core_valid_i) w_state_nx = S_ROUND;
      S_ROUND:   w_state_nx = S_IDLE;
      default:   w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_mant         <= '0;
      r_exp          <= '0;
      r_er           <= '0;
      r_q            <= '0;
      r_rem          <= '0;
      r_spec_result  <= '0;
      r_spec_invalid <= 1'b0;
      r_wait_cnt     <= '0;
      r_radicand     <= '0;
      r_core_en      <= 1'b0;
      r_result       <= '0;
      r_valid        <= 1'b0;
      r_invalid      <= 1'b0;
      r_inexact      <= 1'b0;
      r_timeout      <= 1'b0;
    end else if (clk_en_i) begin
      r_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_timeout      <= 1'b0;
            r_spec_result  <= w_spec_result;
            r_spec_invalid <= w_spec_invalid;
            r_mant         <= {!w_is_sub, w_frac};
            r_exp          <= w_is_sub ? -10'sd126 : ($signed({2'b00, w_expf}) - 10'sd127);
          end
        end
        S_SPECIAL: begin
          r_result  <= r_spec_result;
          r_valid   <= 1'b1;
          r_invalid <= r_spec_invalid;
          r_inexact <= 1'b0;
        end
        S_NORM: begin
          r_mant <= r_mant << 1;
          r_exp  <= r_exp - 10'sd1;
        end
        S_ISSUE: begin
          // Odd exponent folds a factor of 2 into the radicand so the root exponent is e/2.
          if (r_exp[0]) r_radicand <= {r_mant, {(DATA_WIDTH-OUT_WIDTH){1'b0}}};
          else          r_radicand <= {1'b0, r_mant, {(DATA_WIDTH-OUT_WIDTH-1){1'b0}}};
          r_er       <= r_exp[8:1] + 8'd127;
          r_core_en  <= 1'b1;
          r_wait_cnt <= '0;
        end
        S_WAIT: begin
          if (core_valid_i) begin
            r_q       <= core_root_i;
            r_rem     <= core_remainder_i;
            r_core_en <= 1'b0;
          end else begin
            if (r_wait_cnt != CW'(MAX_WAIT)) r_wait_cnt <= r_wait_cnt + 1'b1;
            if (r_wait_cnt == CW'(MAX_WAIT - 1)) r_timeout <= 1'b1;
          end
        end
        S_ROUND: begin
          r_result  <= {1'b0, w_er_fin, w_mant_rnd};
          r_valid   <= 1'b1;
          r_invalid <= 1'b0;
          r_inexact <= |r_rem;
        end
        default: ;
      endcase
    end
  end

  assign core_radicand_o = r_radicand;
  assign core_en_o       = r_core_en;
  assign result_o        = r_result;
  assign valid_o         = r_valid;
  assign invalid_o       = r_invalid;
  assign inexact_o       = r_inexact;
  assign core_timeout_o  = r_timeout;

endmodule

// File: tb/tb_mgt_01_fsqrt_ctrl.sv
// Self-checking bench for mgt_01_fsqrt_ctrl: behavioural sqrt core stub, directed vector
// table, multi-cycle corner sequences and random operands against a real-arithmetic model.
module tb_mgt_01_fsqrt_ctrl;
  localparam int unsigned MAX_WAIT = 32;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b1;
  logic        clk_en_i = 1'b1;
  logic        valid_i = 1'b0;
  logic [31:0] operand_i = '0;
  logic        ready_o;
  logic [47:0] core_radicand_o;
  logic        core_en_o;
  logic [23:0] core_root_i = '0;
  logic [24:0] core_remainder_i = '0;
  logic        core_valid_i = 1'b0;
  logic [31:0] result_o;
  logic        valid_o, invalid_o, inexact_o, core_timeout_o;

  int n_checks = 0;
  int n_err = 0;
  int stub_lat = 0;
  bit st_started = 1'b0;
  int st_cnt = 0;
  longint unsigned st_v, st_q;

  mgt_01_fsqrt_ctrl #(.DATA_WIDTH(48), .OUT_WIDTH(24), .MAX_WAIT(MAX_WAIT)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .clk_en_i(clk_en_i), .valid_i(valid_i),
    .operand_i(operand_i), .ready_o(ready_o), .core_radicand_o(core_radicand_o),
    .core_en_o(core_en_o), .core_root_i(core_root_i), .core_remainder_i(core_remainder_i),
    .core_valid_i(core_valid_i), .result_o(result_o), .valid_o(valid_o),
    .invalid_o(invalid_o), .inexact_o(inexact_o), .core_timeout_o(core_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic longint unsigned isqrt(input longint unsigned v);
    longint unsigned q;
    real rv;
    rv = v;
    q = longint'($rtoi($sqrt(rv)));
    while (q * q > v) q--;
    while ((q + 1) * (q + 1) <= v) q++;
    return q;
  endfunction

  // Sqrt core stub: starts on a core_en rise, counts only enabled cycles, holds valid until en drops.
  always @(negedge clk_i) begin
    if (!core_en_o) begin
      st_started   = 1'b0;
      core_valid_i = 1'b0;
    end else if (!st_started) begin
      st_started       = 1'b1;
      st_cnt           = stub_lat;
      st_v             = {16'd0, core_radicand_o};
      st_q             = isqrt(st_v);
      core_root_i      = st_q[23:0];
      st_v             = st_v - st_q * st_q;
      core_remainder_i = st_v[24:0];
      core_valid_i     = (st_cnt == 0);
    end else if (clk_en_i && st_cnt > 0) begin
      st_cnt--;
      core_valid_i = (st_cnt == 0);
    end
  end

  // Reference: IEEE sqrt via double precision, then RNE to single (double rounding is safe for sqrt).
  function automatic void ref_sqrt(input logic [31:0] x, output logic [31:0] r,
                                   output logic inv, output logic inx);
    logic [7:0]  ex;
    logic [22:0] fr;
    logic [63:0] b;
    logic [28:0] rest;
    logic [24:0] m;
    logic        up;
    real         d, back;
    int          fe;
    ex = x[30:23]; fr = x[22:0]; inv = 1'b0; inx = 1'b0; r = '0;
    if (ex == 8'hFF && fr != 0)      begin r = 32'h7FC00000; inv = 1'b1; end
    else if (ex == 0 && fr == 0)     r = x;
    else if (x[31])                  begin r = 32'h7FC00000; inv = 1'b1; end
    else if (ex == 8'hFF)            r = 32'h7F800000;
    else begin
      if (ex == 0) begin
        d = fr;
        d = d * $bitstoreal({1'b0, 11'd874, 52'd0});
      end else begin
        d = $bitstoreal({1'b0, 11'(ex) + 11'd896, fr, 29'd0});
      end
      b    = $realtobits($sqrt(d));
      rest = b[28:0];
      up   = (rest > 29'h10000000) || (rest == 29'h10000000 && b[29]);
      m    = {2'b01, b[51:29]} + {24'd0, up};
      fe   = int'(b[62:52]) - 1023 + 127;
      if (m[24]) fe++;
      r    = {1'b0, fe[7:0], m[22:0]};
      back = $bitstoreal({1'b0, 11'(fe + 896), m[22:0], 29'd0});
      inx  = (back * back != d);
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  logic [31:0] g_res;
  logic        g_inv, g_inx, g_tmo;
  logic [47:0] g_rad;
  int          g_total, g_en_rise;
  bit          g_done, g_stall_ok, g_pulse_ok;

  // One transaction; valid_i stays high with a different operand while busy to show it is ignored.
  task automatic run_op(input logic [31:0] op, input int lat, input int stall_at);
    int n;
    logic [83:0] snap;
    stub_lat = lat; g_done = 1'b0; g_stall_ok = 1'b1; g_pulse_ok = 1'b0;
    g_en_rise = -1; g_rad = '0; g_total = 0;
    valid_i = 1'b1; operand_i = op;
    n = 0;
    while (!ready_o && n < 100) begin step(); n++; end
    step();
    operand_i = 32'h3F800000;
    while (g_total < 400) begin
      if (g_total == stall_at) begin
        snap = {ready_o, core_en_o, valid_o, core_timeout_o, result_o, core_radicand_o};
        clk_en_i = 1'b0;
        repeat (5) begin
          step(); g_total++;
          if ({ready_o, core_en_o, valid_o, core_timeout_o, result_o, core_radicand_o} !== snap)
            g_stall_ok = 1'b0;
        end
        clk_en_i = 1'b1;
      end
      step(); g_total++;
      if (core_en_o && g_en_rise < 0) begin g_en_rise = g_total; g_rad = core_radicand_o; end
      if (valid_o) begin g_done = 1'b1; break; end
    end
    valid_i = 1'b0;
    g_res = result_o; g_inv = invalid_o; g_inx = inexact_o; g_tmo = core_timeout_o;
    if (g_done) begin
      step();
      g_pulse_ok = !valid_o && ready_o && (result_o == g_res);
    end
    chk("done", 64'(g_done), 64'd1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"},   64'(ready_o), 64'd1);
    chk({tag, "_valid"},   64'(valid_o), 64'd0);
    chk({tag, "_core_en"}, 64'(core_en_o), 64'd0);
    chk({tag, "_result"},  64'(result_o), 64'd0);
    chk({tag, "_rad"},     64'(core_radicand_o), 64'd0);
    chk({tag, "_flags"},   64'({invalid_o, inexact_o, core_timeout_o}), 64'd0);
  endtask

  typedef struct {
    logic [31:0] op;
    logic [31:0] res;
    logic        inv;
    logic        inx;
    int          en_rise;
    int          total;
    logic [47:0] rad;
  } vec_t;

  vec_t tv[16];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] op, er;
    logic        ei, ex;
    int          sel;

    // Stub latency 2: normal path = 3 + 2 edges, each NORM cycle adds one; specials take 1.
    tv[0]  = '{32'h40800000, 32'h40000000, 1'b0, 1'b0,  1,  5, 48'h400000000000};
    tv[1]  = '{32'h40000000, 32'h3FB504F3, 1'b0, 1'b1,  1,  5, 48'h800000000000};
    tv[2]  = '{32'h41100000, 32'h40400000, 1'b0, 1'b0,  1,  5, 48'h900000000000};
    tv[3]  = '{32'h3F800000, 32'h3F800000, 1'b0, 1'b0,  1,  5, 48'h400000000000};
    tv[4]  = '{32'h407FFFFF, 32'h3FFFFFFF, 1'b0, 1'b1,  1,  5, 48'hFFFFFF000000};
    tv[5]  = '{32'h00800000, 32'h20000000, 1'b0, 1'b0,  1,  5, 48'h400000000000};
    tv[6]  = '{32'h00400000, 32'h1FB504F3, 1'b0, 1'b1,  2,  6, 48'h800000000000};
    tv[7]  = '{32'h00000001, 32'h1A3504F3, 1'b0, 1'b1, 24, 28, 48'h800000000000};
    tv[8]  = '{32'hBF800000, 32'h7FC00000, 1'b1, 1'b0, -1,  1, 48'h0};
    tv[9]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, -1,  1, 48'h0};
    tv[10] = '{32'h7F800000, 32'h7F800000, 1'b0, 1'b0, -1,  1, 48'h0};
    tv[11] = '{32'h7FA00000, 32'h7FC00000, 1'b1, 1'b0, -1,  1, 48'h0};
    tv[12] = '{32'h00000000, 32'h00000000, 1'b0, 1'b0, -1,  1, 48'h0};
    tv[13] = '{32'hFF800000, 32'h7FC00000, 1'b1, 1'b0, -1,  1, 48'h0};
    tv[14] = '{32'hFFC00000, 32'h7FC00000, 1'b1, 1'b0, -1,  1, 48'h0};
    tv[15] = '{32'h80000001, 32'h7FC00000, 1'b1, 1'b0, -1,  1, 48'h0};

    #1 rst_n_i = 1'b0;
    #1 chk_reset("reset_async");
    repeat (3) step();
    chk_reset("reset_held");
    rst_n_i = 1'b1;
    step();

    for (int i = 0; i < 16; i++) begin
      run_op(tv[i].op, 2, -1);
      chk($sformatf("vec%0d_res", i), 64'(g_res), 64'(tv[i].res));
      chk($sformatf("vec%0d_inv", i), 64'(g_inv), 64'(tv[i].inv));
      chk($sformatf("vec%0d_inx", i), 64'(g_inx), 64'(tv[i].inx));
      chk($sformatf("vec%0d_latency", i), 64'(g_total), 64'(tv[i].total));
      chk($sformatf("vec%0d_en_rise", i), 64'(g_en_rise), 64'(tv[i].en_rise));
      if (tv[i].en_rise >= 0) chk($sformatf("vec%0d_rad", i), 64'(g_rad), 64'(tv[i].rad));
      chk($sformatf("vec%0d_pulse", i), 64'(g_pulse_ok), 64'd1);
    end

    run_op(32'h40000000, 6, -1);
    chk("stall_base_latency", 64'(g_total), 64'd9);
    run_op(32'h40000000, 6, 2);
    chk("stall_latency", 64'(g_total), 64'd14);
    chk("stall_hold", 64'(g_stall_ok), 64'd1);
    chk("stall_res", 64'(g_res), 64'h3FB504F3);
    chk("stall_inx", 64'(g_inx), 64'd1);

    run_op(32'h41100000, MAX_WAIT - 1, -1);
    chk("wait_under_tmo", 64'(g_tmo), 64'd0);
    run_op(32'h41100000, MAX_WAIT + 2, -1);
    chk("tmo_set", 64'(g_tmo), 64'd1);
    chk("tmo_res", 64'(g_res), 64'h40400000);
    chk("tmo_latency", 64'(g_total), 64'(3 + MAX_WAIT + 2));
    chk("tmo_sticky", 64'(core_timeout_o), 64'd1);
    run_op(32'h40800000, 0, -1);
    chk("tmo_cleared", 64'(g_tmo), 64'd0);
    chk("tmo_next_res", 64'(g_res), 64'h40000000);

    stub_lat = 20;
    valid_i = 1'b1; operand_i = 32'h40800000;
    step();
    valid_i = 1'b0;
    step(); step();
    chk("rst_pre_core_en", 64'(core_en_o), 64'd1);
    #2 rst_n_i = 1'b0;
    #1 chk_reset("rst_mid_wait");
    step();
    rst_n_i = 1'b1;
    step();
    run_op(32'h40800000, 2, -1);
    chk("rst_after_res", 64'(g_res), 64'h40000000);
    chk("rst_after_inx", 64'(g_inx), 64'd0);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      op = $urandom;
      case (sel)
        0: op[30:23] = 8'h00;
        1: op[30:23] = 8'hFF;
        2: op[31] = 1'b1;
        default: op[31] = 1'b0;
      endcase
      ref_sqrt(op, er, ei, ex);
      run_op(op, int'($urandom_range(0, 5)), -1);
      chk($sformatf("rand%0d_res_%h", i, op), 64'(g_res), 64'(er));
      chk($sformatf("rand%0d_inv_%h", i, op), 64'(g_inv), 64'(ei));
      chk($sformatf("rand%0d_inx_%h", i, op), 64'(g_inx), 64'(ex));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
